// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock with a registered
// inter-chunk carry, valid/ready on both sides, registered sum/carry/overflow/zero results.
module chunked_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Pin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Pout,
  output logic             V,
  output logic             Z
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] be_reg;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] work_next;
  logic             v_next;

  logic accept;
  logic last_chunk;
  logic retire;

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign last_chunk = (state == CALC) && (idx == LAST_IDX);
  assign retire     = (state == DONE) && out_ready;
  assign out_valid  = (state == DONE);

  // One chunk of the ripple: the slice selected by idx plus the carry left by the previous chunk
  always_comb begin
    a_chunk   = a_reg[int'(idx)*CHUNK +: CHUNK];
    b_chunk   = be_reg[int'(idx)*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    work_next = work;
    work_next[int'(idx)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    v_next    = (a_reg[WIDTH-1] == be_reg[WIDTH-1]) && (work_next[WIDTH-1] != a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept)     next_state = CALC;
      CALC: if (last_chunk) next_state = DONE;
      DONE: if (retire)     next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // in_ready is registered so it stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= (next_state == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      be_reg <= '0;
      work   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      a_reg  <= A;
      be_reg <= B ^ {WIDTH{SUB}};
      work   <= '0;
      carry  <= Pin ^ SUB;
      idx    <= '0;
    end else if (state == CALC) begin
      work  <= work_next;
      carry <= chunk_sum[CHUNK];
      if (!last_chunk) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  // Visible results only change when an operation completes, so they hold through IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Pout <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b0;
    end else if (last_chunk) begin
      S    <= work_next;
      Pout <= chunk_sum[CHUNK];
      V    <= v_next;
      Z    <= ~|work_next;
    end
  end

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench for chunked_adder_seq: scoreboard of expected results, default 8-bit chunk
// instance plus a single-cycle (CHUNK == WIDTH) instance.
module tb_chunked_adder_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] s;
    logic         pout;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, s;
  logic         pin, sub, pout, v, z;

  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [W-1:0] a1, b1, s1;
  logic         pin1, sub1, pout1, v1, z1;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chunked_adder_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Pin(pin), .SUB(sub), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Pout(pout), .V(v), .Z(z)
  );

  chunked_adder_seq #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .Pin(pin1), .SUB(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .S(s1), .Pout(pout1), .V(v1), .Z(z1)
  );

  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fpin, input logic fsub);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   full;
    be     = fsub ? ~fb : fb;
    full   = {1'b0, fa} + {1'b0, be} + {{W{1'b0}}, fpin ^ fsub};
    e.s    = full[W-1:0];
    e.pout = full[W];
    e.v    = (fa[W-1] == be[W-1]) && (full[W-1] != fa[W-1]);
    e.z    = (full[W-1:0] == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ipin,
                       input logic isub, input string name);
    int cnt;
    cnt = 0;
    in_valid = 1'b1;
    a = ia; b = ib; pin = ipin; sub = isub;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("[TB] FAIL %s accept: in_ready=%0b required 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat, input string name);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (!out_valid || cnt != lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d edges (out_valid=%0b) required %0d", name, cnt, out_valid, lat);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard: result with no expected entry", name);
      return;
    end
    e = sb.pop_front();
    if (s !== e.s) begin
      errors++;
      $display("[TB] FAIL %s S: got %h required %h", name, s, e.s);
    end
    checks++;
    if (pout !== e.pout) begin
      errors++;
      $display("[TB] FAIL %s Pout: got %b required %b", name, pout, e.pout);
    end
    checks++;
    if (v !== e.v) begin
      errors++;
      $display("[TB] FAIL %s V: got %b required %b", name, v, e.v);
    end
    checks++;
    if (z !== e.z) begin
      errors++;
      $display("[TB] FAIL %s Z: got %b required %b", name, z, e.z);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ipin,
                        input logic isub, input exp_t e, input string name);
    sb.push_back(e);
    issue(ia, ib, ipin, isub, name);
    wait_result(4, name);
    pop_check(name);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s retire: out_valid=%b required 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || s !== '0 || pout !== 1'b0 || v !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b S=%h Pout=%b V=%b Z=%b required all 0",
               in_ready, out_valid, s, pout, v, z);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b required 0 before first edge", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_edge_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    run_op(32'd1995, 32'd1996, 1'b1, 1'b0, '{32'd3992, 1'b0, 1'b0, 1'b0}, "add_1995");
    run_op(32'd40067, 32'd73469, 1'b1, 1'b0, '{32'd113537, 1'b0, 1'b0, 1'b0}, "add_40067");
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, '{32'd0, 1'b1, 1'b0, 1'b1}, "add_ripple_wrap");
  endtask

  task automatic test_sub();
    run_op(32'd100, 32'd50, 1'b0, 1'b1, '{32'd50, 1'b1, 1'b0, 1'b0}, "sub_100_50");
    run_op(32'd0, 32'd1, 1'b0, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}, "sub_borrow");
  endtask

  task automatic test_overflow();
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}, "ovf_add");
    run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, "ovf_sub");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rpin, rsub;
    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rb   = (i == 3) ? ra : $urandom;
      rpin = 1'($urandom_range(0, 1));
      rsub = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i == 3) rpin = 1'b0;
      run_op(ra, rb, rpin, rsub, model(ra, rb, rpin, rsub), "random");
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    e = model(32'h1234_5678, 32'h0F0F_F0F0, 1'b0, 1'b0);
    out_ready = 1'b0;
    sb.push_back(e);
    issue(32'h1234_5678, 32'h0F0F_F0F0, 1'b0, 1'b0, "bp");
    wait_result(4, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; pin = 1'b1; sub = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== e.s) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b S=%h required 1/0/%h",
                 i, out_valid, in_ready, s, e.s);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pop_check("bp_release");
    tick();
    checks++;
    if (out_valid !== 1'b0 || s !== e.s || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_idle_hold: out_valid=%b S=%h in_ready=%b required 0/%h/1",
               out_valid, s, in_ready, e.s);
    end
    run_op(32'd7, 32'd9, 1'b0, 1'b0, '{32'd16, 1'b0, 1'b0, 1'b0}, "bp_next_op");
  endtask

  task automatic test_reset_mid_calc();
    sb.push_back(model(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0));
    issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, "rst_mid");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || s !== '0 || pout !== 1'b0 || v !== 1'b0 || z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: out_valid=%b in_ready=%b S=%h Pout=%b V=%b Z=%b required all 0",
               out_valid, in_ready, s, pout, v, z);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_mid_no_result cycle %0d: out_valid=%b required 0", i, out_valid);
      end
    end
    run_op(32'd5, 32'd3, 1'b1, 1'b1, '{32'd1, 1'b1, 1'b0, 1'b0}, "rst_mid_after");
  endtask

  task automatic op_single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ipin,
                           input logic isub, input exp_t e, input string name);
    int cnt;
    cnt = 0;
    while (!in_ready1 && cnt < 20) begin
      tick();
      cnt++;
    end
    in_valid1 = 1'b1;
    a1 = ia; b1 = ib; pin1 = ipin; sub1 = isub;
    tick();
    in_valid1 = 1'b0;
    cnt = 0;
    while (!out_valid1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (!out_valid1 || cnt != 1) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d edges (out_valid=%b) required 1", name, cnt, out_valid1);
    end
    checks++;
    if (s1 !== e.s || pout1 !== e.pout || v1 !== e.v || z1 !== e.z) begin
      errors++;
      $display("[TB] FAIL %s result: S=%h Pout=%b V=%b Z=%b required %h/%b/%b/%b",
               name, s1, pout1, v1, z1, e.s, e.pout, e.v, e.z);
    end
    tick();
  endtask

  task automatic test_single_cycle();
    op_single(32'd40067, 32'd73469, 1'b1, 1'b0, '{32'd113537, 1'b0, 1'b0, 1'b0}, "single_add");
    op_single(32'h8000_0000, 32'd1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, "single_ovf");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; pin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; pin1 = 1'b0; sub1 = 1'b0;
    tick();
    tick();
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_single_cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
